bus_fifo: RTL and testbench
===========================

# bus_fifo

Bus-attached capture FIFO between free-running PL producer logic and the PS-driven 16-bit register bus. PL logic pushes 16-bit samples; the PS drains them one word per bus read, and reads occupancy and flag status through the bus master FSM. The block sits directly downstream of the bus master. It decodes baddr, bwr and bstrobe exactly as the existing read-only and read/write bus registers do, and shares the tri-stated read-data bus with them.

## Interface
- BASEADDR, 16'h0010: first of 4 consecutive bus addresses; must be 4-aligned.
- AW, 4: FIFO address width; depth = 2**AW words.
- clk  in  1  single clock, the bus clock (fclk0). All logic is on this clock.
- rst  in  1  asynchronous, active-high reset.
- baddr  in  16  bus address from the bus master.
- bwr  in  1  bus write qualifier.
- bstrobe  in  1  one-cycle bus operation strobe.
- bwrdata  in  16  bus write data.
- brddata  out  16  read data; driven only when baddr is in BASEADDR..BASEADDR+3, otherwise 16'hzzzz.
- din  in  16  sample from the PL producer.
- din_valid  in  1  push request. The producer never stalls.
- din_ready  out  1  equals !full; informational only.

## Operation
- Register map, as offsets from BASEADDR:
  - +0 STATUS (RO): [15]=full, [14]=empty, [13]=overflow (sticky), [12]=underflow (sticky), [AW:0]=count.
  - +1 DATA (RO): head word, first-word-fall-through. The read itself pops the word.
  - +2 CTRL (WO, reads 0): bit0=flush, bit1=clear sticky flags. Both bits are self-clearing.
  - +3 DROPS (RO): saturating count of dropped pushes; saturates at 16'hffff.
- Push condition: din_valid=1 at a rising edge.
  - If not full: write din at wptr; wptr+1 mod 2**AW; count+1.
  - If full: the word is dropped. Set overflow and increment DROPS (saturating).
- Pop condition: bstrobe=1, bwr=0, baddr=BASEADDR+1.
  - If not empty: rptr+1; count-1.
  - If empty: DATA returns 16'h0000, no pointer change, underflow is set.
- Simultaneous push and pop, 0<count<2**AW: both take effect; count unchanged.
- Simultaneous push and pop when empty: the push is accepted and the pop is treated as underflow.
- Simultaneous push and pop when full: the pop is accepted and the push is dropped and counted, because din_ready=0.
- CTRL write takes effect when bstrobe=1, bwr=1, baddr=BASEADDR+2.
  - Flush: pointers and count go to 0. Flush wins over a same-cycle push. The lost push is not counted in DROPS.
  - Clear flags: zeroes overflow, underflow and DROPS. If a drop or underflow occurs in the same cycle, the new event wins: the flag is set and DROPS=1.
- Writes to +0, +1 and +3 are ignored.
- count is AW+1 bits wide. full ⇔ count==2**AW; empty ⇔ count==0.
- Reset values:
  - pointers, count, flags and DROPS are 0;
  - din_ready=1;
  - brddata follows the address decode.
  - Storage contents are not reset.
- Reset mid-operation: the FIFO is empty immediately. A subsequent DATA read returns 0 and sets underflow.

## Timing
- brddata is combinational from baddr and the current state.
  - It must be valid in the cycle bstrobe is high, because the bus master captures read data in that cycle.
  - The pop and the status update occur at the edge that ends the bstrobe cycle.
- Push-to-visibility latency:
  - a word pushed at edge N is the DATA head from cycle N+1 when the FIFO was empty;
  - STATUS.count reflects the push from cycle N+1.
- Sticky flags and DROPS update at the same edge as the triggering event.
- Throughput: one push per cycle; one pop per bus transaction, at most one per 4 clocks because of the bus master FSM.

## Structure
- Shared package bus_fifo_pkg holds:
  - register offsets: OFS_STATUS=0, OFS_DATA=1, OFS_CTRL=2, OFS_DROPS=3;
  - STATUS bit positions;
  - CTRL bit positions.
- Sub-module bus_fifo_mem: 2**AW×16 storage, one synchronous write port and one asynchronous read port at rptr. No reset.
- Top level holds pointers, count, flags, DROPS, address decode and the tri-state read mux.

## Test plan
- Reset, then read +0 → 16'h4000 (empty). Read +1 → 16'h0000; then read +0 → 16'h5000 (underflow set).
- Push 3 words 0x1111, 0x2222, 0x3333; read +0 → count=3. Three reads of +1 → 0x1111, 0x2222, 0x3333; then +0 → 16'h4000.
- Push 18 words with AW=4:
  - the first 16 are stored; din_ready=0 after the 16th;
  - +0 → 16'hA010 (full, overflow, count=16);
  - +3 → 2;
  - draining returns words 1..16 in order.
- Fill to count=5, then pulse din_valid in the same cycle as the DATA bstrobe → count stays 5; pointer wrap is exercised by repeating this past 2**AW total writes.
- Fill to 7, write CTRL=0x0003 with a same-cycle din_valid → count=0, flags clear, DROPS=0, the next DATA read underflows.
- Assert rst asynchronously mid-fill (between clock edges) → status immediately reads 16'h4000 and din_ready=1.
- Read an address outside BASEADDR..+3 → brddata=16'hzzzz.

Source files
------------

// File: rtl/bus_fifo_pkg.sv
// Shared definitions for the bus-attached capture FIFO: register offsets,
// STATUS/CTRL bit positions and bus word width.
package bus_fifo_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned OFS_W  = 2;

  localparam logic [OFS_W-1:0] OFS_STATUS = 2'd0;
  localparam logic [OFS_W-1:0] OFS_DATA   = 2'd1;
  localparam logic [OFS_W-1:0] OFS_CTRL   = 2'd2;
  localparam logic [OFS_W-1:0] OFS_DROPS  = 2'd3;

  localparam int unsigned ST_FULL  = 15;
  localparam int unsigned ST_EMPTY = 14;
  localparam int unsigned ST_OVF   = 13;
  localparam int unsigned ST_UNF   = 12;

  localparam int unsigned CTRL_FLUSH = 0;
  localparam int unsigned CTRL_CLR   = 1;

  localparam logic [DATA_W-1:0] DROPS_MAX = 16'hffff;

endpackage

// File: rtl/bus_fifo_mem.sv
// FIFO storage: one synchronous write port, one asynchronous read port.
// Contents are intentionally not reset.
module bus_fifo_mem
  import bus_fifo_pkg::*;
#(
  parameter int unsigned AW = 4
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [AW-1:0]     i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [AW-1:0]     i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  localparam int unsigned DEPTH = 2 ** AW;

  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/bus_fifo.sv
// Capture FIFO between a free-running PL producer and the 16-bit register bus.
// Four registers at BASEADDR..+3; read data is tri-stated outside that window.
module bus_fifo
  import bus_fifo_pkg::*;
#(
  parameter logic [15:0] BASEADDR = 16'h0010,
  parameter int unsigned AW       = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       baddr,
  input  logic              bwr,
  input  logic              bstrobe,
  input  logic [DATA_W-1:0] bwrdata,
  output logic [DATA_W-1:0] brddata,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  output logic              din_ready
);

  localparam int unsigned DEPTH = 2 ** AW;
  localparam int unsigned CW    = AW + 1;

  logic [AW-1:0]     r_wptr;
  logic [AW-1:0]     r_rptr;
  logic [CW-1:0]     r_count;
  logic              r_ovf;
  logic              r_unf;
  logic [DATA_W-1:0] r_drops;

  logic              w_sel;
  logic [OFS_W-1:0]  w_ofs;
  logic              w_full;
  logic              w_empty;
  logic              w_pop_req;
  logic              w_ctrl_wr;
  logic              w_flush;
  logic              w_clr;
  logic              w_push;
  logic              w_pop;
  logic              w_drop;
  logic              w_under;
  logic [DATA_W-1:0] w_mem_rdata;
  logic [DATA_W-1:0] w_status;
  logic [DATA_W-1:0] w_rdata;
  logic              w_unused_wr;

  // Address decode matches the other bus registers: 4-aligned window.
  assign w_sel     = (baddr[15:2] == BASEADDR[15:2]);
  assign w_ofs     = baddr[OFS_W-1:0];
  assign w_full    = (r_count == CW'(DEPTH));
  assign w_empty   = (r_count == '0);
  assign w_pop_req = bstrobe & ~bwr & w_sel & (w_ofs == OFS_DATA);
  assign w_ctrl_wr = bstrobe &  bwr & w_sel & (w_ofs == OFS_CTRL);
  assign w_flush   = w_ctrl_wr & bwrdata[CTRL_FLUSH];
  assign w_clr     = w_ctrl_wr & bwrdata[CTRL_CLR];

  // A push lost to a flush is neither stored nor counted as a drop.
  assign w_push    = din_valid & ~w_full & ~w_flush;
  assign w_drop    = din_valid &  w_full & ~w_flush;
  assign w_pop     = w_pop_req & ~w_empty;
  assign w_under   = w_pop_req &  w_empty;

  assign din_ready   = ~w_full;
  assign w_unused_wr = ^bwrdata[DATA_W-1:2];

  bus_fifo_mem #(
    .AW(AW)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_push),
    .i_waddr (r_wptr),
    .i_wdata (din),
    .i_raddr (r_rptr),
    .o_rdata (w_mem_rdata)
  );

  // Pointers, occupancy, sticky flags and drop counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
      r_drops <= '0;
    end else begin
      if (w_flush) begin
        r_wptr  <= '0;
        r_rptr  <= '0;
        r_count <= '0;
      end else begin
        if (w_push) begin
          r_wptr <= r_wptr + AW'(1);
        end
        if (w_pop) begin
          r_rptr <= r_rptr + AW'(1);
        end
        r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end

      // A same-cycle event beats the clear request.
      if (w_drop) begin
        r_ovf <= 1'b1;
      end else if (w_clr) begin
        r_ovf <= 1'b0;
      end

      if (w_under) begin
        r_unf <= 1'b1;
      end else if (w_clr) begin
        r_unf <= 1'b0;
      end

      if (w_clr) begin
        r_drops <= w_drop ? DATA_W'(1) : '0;
      end else if (w_drop && (r_drops != DROPS_MAX)) begin
        r_drops <= r_drops + DATA_W'(1);
      end
    end
  end

  // Read mux; must be valid combinationally in the strobe cycle.
  always_comb begin
    w_status           = '0;
    w_status[ST_FULL]  = w_full;
    w_status[ST_EMPTY] = w_empty;
    w_status[ST_OVF]   = r_ovf;
    w_status[ST_UNF]   = r_unf;
    w_status[AW:0]     = r_count;

    w_rdata = '0;
    case (w_ofs)
      OFS_STATUS: w_rdata = w_status;
      OFS_DATA:   w_rdata = w_empty ? '0 : w_mem_rdata;
      OFS_CTRL:   w_rdata = '0;
      OFS_DROPS:  w_rdata = r_drops;
      default:    w_rdata = '0;
    endcase
  end

  assign brddata = w_sel ? w_rdata : 16'hzzzz;

endmodule

// File: tb/tb_bus_fifo.sv
// Directed bench for bus_fifo; a neighbouring bus register drives 16'hBEEF
// whenever the address lies outside the FIFO window.
module tb_bus_fifo;

  localparam logic [15:0] BASE    = 16'h0010;
  localparam logic [15:0] FOREIGN = 16'hBEEF;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] baddr;
  logic        bwr;
  logic        bstrobe;
  logic [15:0] bwrdata;
  logic [15:0] din;
  logic        din_valid;
  logic        din_ready;
  wire  [15:0] brddata;

  int n_checks = 0;
  int n_errors = 0;

  assign brddata = (baddr[15:2] != BASE[15:2]) ? FOREIGN : 16'hzzzz;

  bus_fifo #(
    .BASEADDR (BASE),
    .AW       (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .baddr     (baddr),
    .bwr       (bwr),
    .bstrobe   (bstrobe),
    .bwrdata   (bwrdata),
    .brddata   (brddata),
    .din       (din),
    .din_valid (din_valid),
    .din_ready (din_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic bus_read(input logic [1:0] ofs, input logic [15:0] exp, input string tag);
    @(negedge clk);
    baddr = BASE + 16'(ofs); bwr = 1'b0; bstrobe = 1'b1;
    #1;
    check(tag, brddata, exp);
    @(posedge clk); #1;
    bstrobe = 1'b0; baddr = 16'h0000;
  endtask

  task automatic bus_write(input logic [1:0] ofs, input logic [15:0] data);
    @(negedge clk);
    baddr = BASE + 16'(ofs); bwr = 1'b1; bstrobe = 1'b1; bwrdata = data;
    @(posedge clk); #1;
    bstrobe = 1'b0; bwr = 1'b0; baddr = 16'h0000;
  endtask

  task automatic push(input logic [15:0] d);
    @(negedge clk);
    din = d; din_valid = 1'b1;
    @(posedge clk); #1;
    din_valid = 1'b0;
  endtask

  task automatic push_pop(input logic [15:0] d, input logic [15:0] exp, input string tag);
    @(negedge clk);
    din = d; din_valid = 1'b1;
    baddr = BASE + 16'd1; bwr = 1'b0; bstrobe = 1'b1;
    #1;
    check(tag, brddata, exp);
    @(posedge clk); #1;
    din_valid = 1'b0; bstrobe = 1'b0; baddr = 16'h0000;
  endtask

  task automatic ctrl_push(input logic [15:0] ctrl, input logic [15:0] d);
    @(negedge clk);
    baddr = BASE + 16'd2; bwr = 1'b1; bstrobe = 1'b1; bwrdata = ctrl;
    din = d; din_valid = 1'b1;
    @(posedge clk); #1;
    bstrobe = 1'b0; bwr = 1'b0; din_valid = 1'b0; baddr = 16'h0000;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; baddr = BASE; bwr = 1'b0; bstrobe = 1'b0;
    bwrdata = 16'h0000; din = 16'h0000; din_valid = 1'b0;
    #2;
    check("reset_status", brddata, 16'h4000);
    check("reset_din_ready", 16'(din_ready), 16'h0001);
    @(negedge clk); rst = 1'b0; baddr = 16'h0000;

    // Empty read underflows and returns zero
    bus_read(2'd0, 16'h4000, "status_after_reset");
    bus_read(2'd1, 16'h0000, "empty_data_read");
    bus_read(2'd0, 16'h5000, "status_underflow");
    bus_write(2'd2, 16'h0002);
    bus_read(2'd0, 16'h4000, "status_after_clear");

    // Three words in order; writes to RO registers are ignored
    push(16'h1111); push(16'h2222); push(16'h3333);
    bus_read(2'd0, 16'h0003, "status_count3");
    bus_write(2'd1, 16'hFFFF);
    bus_write(2'd0, 16'hFFFF);
    bus_write(2'd3, 16'hFFFF);
    bus_read(2'd0, 16'h0003, "ro_writes_ignored");
    bus_read(2'd3, 16'h0000, "drops_ro_write_ignored");
    bus_read(2'd2, 16'h0000, "ctrl_reads_zero");
    bus_read(2'd1, 16'h1111, "data_w1");
    bus_read(2'd1, 16'h2222, "data_w2");
    bus_read(2'd1, 16'h3333, "data_w3");
    bus_read(2'd0, 16'h4000, "status_drained3");

    // Overfill by two words
    for (int i = 1; i <= 16; i++) push(16'hA000 + 16'(i));
    check("din_ready_full", 16'(din_ready), 16'h0000);
    push(16'hA011); push(16'hA012);
    bus_read(2'd0, 16'hA010, "status_full_ovf");
    bus_read(2'd3, 16'h0002, "drops_two");
    for (int i = 1; i <= 16; i++) bus_read(2'd1, 16'hA000 + 16'(i), "drain_full");
    bus_read(2'd0, 16'h6000, "status_drained_ovf_sticky");
    bus_write(2'd2, 16'h0002);
    bus_read(2'd3, 16'h0000, "drops_cleared");
    bus_read(2'd0, 16'h4000, "status_flags_cleared");

    // Steady push+pop at count 5, wrapping the pointers
    for (int i = 0; i < 5; i++) push(16'h5000 + 16'(i));
    bus_read(2'd0, 16'h0005, "status_count5");
    for (int j = 0; j < 20; j++)
      push_pop(16'h6000 + 16'(j),
               (j < 5) ? 16'h5000 + 16'(j) : 16'h6000 + 16'(j - 5), "push_pop_head");
    bus_read(2'd0, 16'h0005, "status_count5_after_pp");

    // Flush and clear with a same-cycle push
    push(16'h7001); push(16'h7002);
    bus_read(2'd0, 16'h0007, "status_count7");
    ctrl_push(16'h0003, 16'h7777);
    bus_read(2'd0, 16'h4000, "status_after_flush_clear");
    bus_read(2'd3, 16'h0000, "drops_after_flush_clear");
    bus_read(2'd1, 16'h0000, "data_after_flush");
    bus_read(2'd0, 16'h5000, "status_underflow_after_flush");

    // Clear coinciding with a drop: the drop wins
    bus_write(2'd2, 16'h0002);
    for (int i = 0; i < 16; i++) push(16'h8000 + 16'(i));
    ctrl_push(16'h0002, 16'h9999);
    bus_read(2'd0, 16'hA010, "status_clear_vs_drop");
    bus_read(2'd3, 16'h0001, "drops_clear_vs_drop");
    bus_write(2'd2, 16'h0001);
    bus_read(2'd0, 16'h6000, "status_flush_keeps_flags");
    bus_read(2'd3, 16'h0001, "drops_flush_keeps");

    // Asynchronous reset between edges mid-fill
    push(16'hC001); push(16'hC002); push(16'hC003);
    @(negedge clk);
    din = 16'hC004; din_valid = 1'b1; baddr = BASE;
    #2 rst = 1'b1;
    #1;
    check("async_reset_status", brddata, 16'h4000);
    check("async_reset_din_ready", 16'(din_ready), 16'h0001);
    baddr = BASE + 16'd3;
    #1;
    check("async_reset_drops", brddata, 16'h0000);
    din_valid = 1'b0; baddr = 16'h0000;
    @(negedge clk); rst = 1'b0;
    bus_read(2'd1, 16'h0000, "data_after_reset");
    bus_read(2'd0, 16'h5000, "status_after_reset_read");

    // Decode window edges: neighbours own the bus outside +0..+3
    @(negedge clk);
    baddr = 16'h0014; #1;
    check("outside_above", brddata, FOREIGN);
    baddr = 16'h000F; #1;
    check("outside_below", brddata, FOREIGN);
    baddr = 16'h0013; #1;
    check("window_top_drops", brddata, 16'h0000);
    baddr = 16'h0000;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
